// File: rtl/iact_csc_pkg.sv
// Shared types and constants for the iact compressed-sparse-column encoder.
// Address and data word widths, the row index width and the FSM state encoding live here.
package iact_csc_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 12;
  localparam int ROW_W  = 4;

  localparam logic [ADDR_W-1:0] ZERO_CODE = 7'd127;
  localparam logic [ADDR_W-1:0] CUM_MAX   = 7'd126;
  localparam int                TERM_VAL  = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ENCODE    = 2'd1,
    ST_TERM      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/iact_stream_reg.sv
// One-entry valid/ready output register for the address and data streams.
// A new word may be loaded in the same cycle the current one is consumed.
module iact_stream_reg #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         slot_free,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);

  assign slot_free = !valid || ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/iact_csc_encoder.sv
// Column-major dense activation stream to CSC address/data streams for the iact bank.
// Nonzeros emit {value,row}; each column end emits the cumulative nonzero count.
//
// state     | meaning
// IDLE      | waiting for start
// ENCODE    | consuming dense elements, emitting data and per-column addresses
// TERM      | emitting one 0 terminator on each stream
// WAIT_DONE | waiting for the bank to report iact_write_done
module iact_csc_encoder
  import iact_csc_pkg::*;
#(
  parameter int                MAX_ROWS  = 16,
  parameter logic [ADDR_W-1:0] ZERO_CODE = iact_csc_pkg::ZERO_CODE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W:0]    num_rows,
  input  logic [ADDR_W-1:0] num_cols,
  input  logic              dense_in_valid,
  output logic              dense_in_ready,
  input  logic [7:0]        dense_in,
  output logic              addr_out_valid,
  input  logic              addr_out_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              iact_write_en,
  input  logic              iact_write_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ROW_W:0] ROWS_CAP = (ROW_W+1)'(MAX_ROWS);

  state_t            state;
  logic [ROW_W-1:0]  row_cnt;
  logic [ROW_W:0]    rows_r;
  logic [ADDR_W-1:0] col_cnt, cols_r, cum_cnt, cum_next;
  logic              col_nz, col_nz_next, addr_term_sent, data_term_sent;
  logic              last_row, last_col, accept, is_nz;
  logic              addr_free, data_free, addr_load, data_load;
  logic [ADDR_W-1:0] addr_word;
  logic [DATA_W-1:0] data_word;

  assign last_row    = ({1'b0, row_cnt} == (rows_r - (ROW_W+1)'(1)));
  assign last_col    = (col_cnt == (cols_r - ADDR_W'(1)));
  assign dense_in_ready = (state == ST_ENCODE) && data_free && (!last_row || addr_free);
  assign accept      = dense_in_valid && dense_in_ready;
  assign is_nz       = (dense_in != 8'd0);
  assign cum_next    = (is_nz && cum_cnt != CUM_MAX) ? cum_cnt + ADDR_W'(1) : cum_cnt;
  assign col_nz_next = col_nz || is_nz;
  assign iact_write_en = (state == ST_IDLE) && start;
  assign busy        = (state != ST_IDLE);

  always_comb begin
    data_load = 1'b0;
    data_word = '0;
    addr_load = 1'b0;
    addr_word = '0;
    if (accept) begin
      if (is_nz) begin
        data_load = 1'b1;
        data_word = {dense_in, row_cnt};
      end
      if (last_row) begin
        addr_load = 1'b1;
        addr_word = col_nz_next ? cum_next : ZERO_CODE;
      end
    end
    if (state == ST_TERM) begin
      if (!data_term_sent && data_free) begin
        data_load = 1'b1;
        data_word = DATA_W'(TERM_VAL);
      end
      if (!addr_term_sent && addr_free) begin
        addr_load = 1'b1;
        addr_word = ADDR_W'(TERM_VAL);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      row_cnt        <= '0;
      rows_r         <= '0;
      col_cnt        <= '0;
      cols_r         <= '0;
      cum_cnt        <= '0;
      col_nz         <= 1'b0;
      addr_term_sent <= 1'b0;
      data_term_sent <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          rows_r         <= (num_rows > ROWS_CAP) ? ROWS_CAP : num_rows;
          cols_r         <= num_cols;
          row_cnt        <= '0;
          col_cnt        <= '0;
          cum_cnt        <= '0;
          col_nz         <= 1'b0;
          err            <= 1'b0;
          addr_term_sent <= 1'b0;
          data_term_sent <= 1'b0;
          state <= (num_rows == '0 || num_cols == '0) ? ST_TERM : ST_ENCODE;
        end
        ST_ENCODE: if (accept) begin
          cum_cnt <= cum_next;
          if (is_nz && cum_cnt == CUM_MAX) err <= 1'b1;
          if (last_row) begin
            row_cnt <= '0;
            col_nz  <= 1'b0;
            col_cnt <= col_cnt + ADDR_W'(1);
            if (last_col) state <= ST_TERM;
          end else begin
            row_cnt <= row_cnt + ROW_W'(1);
            col_nz  <= col_nz_next;
          end
        end
        ST_TERM: begin
          if (data_load) data_term_sent <= 1'b1;
          if (addr_load) addr_term_sent <= 1'b1;
          // sent flags rise with the load, so low valids afterwards mean consumed
          if (addr_term_sent && data_term_sent && !addr_out_valid && !data_out_valid)
            state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (iact_write_done) begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  iact_stream_reg #(.W(ADDR_W)) u_addr_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (addr_load),
    .load_data (addr_word),
    .slot_free (addr_free),
    .valid     (addr_out_valid),
    .ready     (addr_out_ready),
    .data      (addr_out)
  );

  iact_stream_reg #(.W(DATA_W)) u_data_reg (
    .clock     (clock),
    .reset     (reset),
    .load      (data_load),
    .load_data (data_word),
    .slot_free (data_free),
    .valid     (data_out_valid),
    .ready     (data_out_ready),
    .data      (data_out)
  );

endmodule

// File: tb/tb_iact_csc_encoder.sv
// Self-checking bench for iact_csc_encoder: directed scenarios plus random matrices
// compared against a queue-based CSC reference model.
module tb_iact_csc_encoder;

  localparam int BUDGET = 6000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  num_rows = '0;
  logic [6:0]  num_cols = '0;
  logic        dense_in_valid = 1'b0;
  logic        dense_in_ready;
  logic [7:0]  dense_in = '0;
  logic        addr_out_valid;
  logic        addr_out_ready = 1'b0;
  logic [6:0]  addr_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b0;
  logic [11:0] data_out;
  logic        iact_write_en;
  logic        iact_write_done = 1'b0;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [7:0] mat [0:2047];
  int exp_data[$];
  int exp_addr[$];
  bit exp_err;

  iact_csc_encoder dut (
    .clock(clock), .reset(reset), .start(start), .num_rows(num_rows), .num_cols(num_cols),
    .dense_in_valid(dense_in_valid), .dense_in_ready(dense_in_ready), .dense_in(dense_in),
    .addr_out_valid(addr_out_valid), .addr_out_ready(addr_out_ready), .addr_out(addr_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready), .data_out(data_out),
    .iact_write_en(iact_write_en), .iact_write_done(iact_write_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CSC reference: nonzeros as value*16+row, per-column running count (capped at 126) or 127
  task automatic build_model(input int rows, input int cols);
    int cum;
    bit any;
    exp_data.delete();
    exp_addr.delete();
    exp_err = 0;
    cum = 0;
    if (rows > 0 && cols > 0) begin
      for (int c = 0; c < cols; c++) begin
        any = 0;
        for (int r = 0; r < rows; r++) begin
          if (mat[c*rows + r] != 0) begin
            exp_data.push_back(int'(mat[c*rows + r]) * 16 + r);
            if (cum >= 126) exp_err = 1;
            else cum++;
            any = 1;
          end
        end
        exp_addr.push_back(any ? cum : 127);
      end
    end
    exp_data.push_back(0);
    exp_addr.push_back(0);
  endtask

  task automatic fill(input int n, input int zero_pct);
    for (int i = 0; i < n; i++)
      mat[i] = ($urandom_range(0, 99) < zero_pct) ? 8'd0 : 8'($urandom_range(1, 255));
  endtask

  // mode 0: readies high; 1: data_out_ready toggles; 2: random readies and input gaps
  task automatic run_job(input int rows, input int cols, input int mode, input bit poke);
    int idx, total, cyc, e;
    bit pdv;
    logic [11:0] pd;
    idx = 0; total = rows * cols; cyc = 0; pdv = 0; pd = '0;
    build_model(rows, cols);
    @(negedge clock);
    start = 1; num_rows = 5'(rows); num_cols = 7'(cols);
    #1;
    chk("write_en_on_start", 32'(iact_write_en), 1);
    chk("idle_before_start", 32'(busy), 0);
    @(negedge clock);
    start = 0; num_rows = 5'($urandom); num_cols = 7'($urandom);
    while ((exp_data.size() > 0 || exp_addr.size() > 0) && cyc < BUDGET) begin
      dense_in_valid = (idx < total) && (mode != 2 || $urandom_range(0, 3) != 0);
      dense_in       = (idx < total) ? mat[idx] : 8'd0;
      data_out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
      addr_out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) chk("busy_after_start", 32'(busy), 1);
      chk("write_en_quiet", 32'(iact_write_en), 0);
      if (rows == 0 || cols == 0) chk("no_encode", 32'(dense_in_ready), 0);
      if (data_out_valid && !data_out_ready) chk("din_blocked", 32'(dense_in_ready), 0);
      if (pdv) begin
        chk("data_hold_valid", 32'(data_out_valid), 1);
        chk("data_hold_value", 32'(data_out), 32'(pd));
      end
      pdv = data_out_valid && !data_out_ready;
      pd  = data_out;
      if (dense_in_valid && dense_in_ready) idx++;
      if (data_out_valid && data_out_ready) begin
        e = (exp_data.size() > 0) ? exp_data.pop_front() : 32'hdead;
        chk("data_word", 32'(data_out), e);
      end
      if (addr_out_valid && addr_out_ready) begin
        e = (exp_addr.size() > 0) ? exp_addr.pop_front() : 32'hdead;
        chk("addr_word", 32'(addr_out), e);
      end
      cyc++;
      @(negedge clock);
    end
    chk("job_in_budget", 32'(cyc < BUDGET), 1);
    chk("all_input_taken", idx, total);
    dense_in_valid = 0; data_out_ready = 1; addr_out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("no_extra_data", 32'(data_out_valid), 0);
      chk("no_extra_addr", 32'(addr_out_valid), 0);
      @(negedge clock);
    end
    chk("err_final", 32'(err), 32'(exp_err));
    chk("busy_wait_done", 32'(busy), 1);
    if (poke) begin
      start = 1; num_rows = 5'd1; num_cols = 7'd1;
      #1;
      chk("start_ignored", 32'(iact_write_en), 0);
      @(negedge clock);
      start = 0;
      #1;
      chk("still_waiting", 32'(busy), 1);
      @(negedge clock);
    end
    iact_write_done = 1;
    #1;
    chk("done_not_early", 32'(done), 0);
    @(negedge clock);
    iact_write_done = 0;
    #1;
    chk("done_pulse", 32'(done), 1);
    chk("idle_after_done", 32'(busy), 0);
    @(negedge clock);
    #1;
    chk("done_single", 32'(done), 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valids", 32'({addr_out_valid, data_out_valid}), 0);
    chk("rst_outs", 32'({addr_out, data_out}), 0);
    chk("rst_flags", 32'({done, err, dense_in_ready, iact_write_en}), 0);
    @(negedge clock);
    reset = 1;

    // 4x2: 5,0,0,7 | 0,0,0,0
    for (int i = 0; i < 8; i++) mat[i] = 8'd0;
    mat[0] = 8'd5; mat[3] = 8'd7;
    run_job(4, 2, 0, 1);

    // write_done while idle is ignored
    @(negedge clock);
    iact_write_done = 1;
    @(negedge clock);
    iact_write_done = 0;
    #1;
    chk("done_ignored_idle", 32'(done), 0);
    chk("idle_stays", 32'(busy), 0);

    // 2x3 all nonzero with data backpressure
    fill(6, 0);
    run_job(2, 3, 1, 0);

    run_job(3, 0, 0, 0);
    run_job(0, 5, 2, 0);

    // 16x8 all nonzero overflows the count
    fill(128, 0);
    run_job(16, 8, 0, 0);

    // reset mid-encode with both output valids high
    @(negedge clock);
    start = 1; num_rows = 5'd4; num_cols = 7'd4;
    @(negedge clock);
    start = 0; data_out_ready = 0; addr_out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      dense_in_valid = 1;
      dense_in = (k == 3) ? 8'd9 : 8'd0;
      @(negedge clock);
    end
    dense_in_valid = 0;
    #1;
    chk("pre_rst_valids", 32'({addr_out_valid, data_out_valid}), 3);
    #2;
    reset = 0;
    #1;
    chk("async_rst_valids", 32'({addr_out_valid, data_out_valid}), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_outs", 32'({addr_out, data_out}), 0);
    chk("async_rst_ready", 32'(dense_in_ready), 0);
    @(negedge clock);
    reset = 1;
    fill(12, 30);
    run_job(3, 4, 0, 0);

    // random matrices with random handshakes
    for (int t = 0; t < 4; t++) begin
      int r, c;
      r = $urandom_range(1, 16);
      c = $urandom_range(1, 12);
      fill(r * c, $urandom_range(20, 80));
      run_job(r, c, 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iact_csc_encoder.md
IACT_CSC_ENCODER -- requirements
Module: iact_csc_encoder

Interface
REQ-001 SHALL have parameter MAX_ROWS, 16, maximum rows per column (row index 4 bits).
REQ-002 SHALL have parameter ZERO_CODE, 7'd127, address word emitted for a column with no nonzeros.
REQ-003 SHALL have clock: input, 1 bit, single clock domain, all state on rising edge.
REQ-004 SHALL have reset: input, 1 bit, asynchronous, active-low (0 = reset).
REQ-005 SHALL have start (in, 1), num_rows (in, 5, 1..16) and num_cols (in, 7, 1..126); num_rows and num_cols are sampled when start is accepted.
REQ-006 SHALL have dense_in_valid (in, 1), dense_in_ready (out, 1) and dense_in (in, 8), dense activations in column-major order.
REQ-007 SHALL have addr_out_valid (out, 1), addr_out_ready (in, 1) and addr_out (out, 7), driving the bank address-in stream.
REQ-008 SHALL have data_out_valid (out, 1), data_out_ready (in, 1) and data_out (out, 12), driving the bank data-in stream.
REQ-009 SHALL have iact_write_en (out, 1) and iact_write_done (in, 1) for the bank write handshake.
REQ-010 SHALL have busy (out, 1), done (out, 1, single-cycle pulse) and err (out, 1, sticky count overflow).

Function
REQ-011 SHALL use FSM states IDLE, ENCODE, TERM and WAIT_DONE.
REQ-012 In IDLE, start=1 SHALL move to ENCODE, pulse iact_write_en for exactly that cycle, and clear row, column and cumulative counters and err.
REQ-013 If num_rows=0 or num_cols=0 is sampled, the FSM SHALL go IDLE->TERM instead of ENCODE, and iact_write_en SHALL still pulse.
REQ-014 start SHALL be ignored outside IDLE.
REQ-015 Each stream SHALL have a one-entry output register; valid stays high, with data stable, until ready=1.
REQ-016 A register SHALL accept a new word in the same cycle its current word is consumed (full throughput).
REQ-017 dense_in_ready SHALL be 1 only in ENCODE with the data slot free-or-draining and, on the last row of a column, the address slot free-or-draining.
REQ-018 An accepted nonzero element SHALL load data_out={value[7:0], row[3:0]} in the next cycle (1-cycle latency); a zero element SHALL be consumed with no output.
REQ-019 On acceptance of a column's last row, the address register SHALL load the cumulative nonzero count including that column, or ZERO_CODE if the column held no nonzeros.
REQ-020 The cumulative count SHALL saturate at 126; any increment beyond 126 SHALL set err, and err SHALL hold until the next accepted start.
REQ-021 The row counter SHALL wrap to 0 after num_rows-1 and advance the column counter; acceptance of the last element of column num_cols-1 SHALL move the FSM to TERM.
REQ-022 In TERM, each stream SHALL emit exactly one 0 terminator, independently, once its slot is free.
REQ-023 The FSM SHALL move TERM->WAIT_DONE when both terminators have been consumed.
REQ-024 In WAIT_DONE, iact_write_done=1 SHALL pulse done for 1 cycle and return to IDLE.
REQ-025 iact_write_done outside WAIT_DONE SHALL be ignored.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, clear all counters and both output registers, and drive valids, iact_write_en, busy, done, err and dense_in_ready to 0, including mid-operation.
REQ-028 addr_out and data_out SHALL reset to 0.
REQ-029 After reset release, the first accepted start SHALL behave as from power-up.

Structure
REQ-030 Package iact_csc_pkg SHALL hold the state enum, ZERO_CODE, terminator value 0, and ADDR_W=7, DATA_W=12, ROW_W=4.
REQ-031 The one-entry valid/ready output register SHALL be sub-module iact_stream_reg, instantiated twice (widths 7 and 12).

Verification
REQ-032 Scenario: rows=4, cols=2, input 5,0,0,7 | 0,0,0,0, all readies 1 -> data 0x050, 0x073, 0x000; addr 2, 127, 0; done pulses 1 cycle after iact_write_done.
REQ-033 Scenario: rows=2, cols=3, all-nonzero input, data_out_ready toggling every other cycle -> no word lost or duplicated; addr 2, 4, 6, 0; dense_in_ready low whenever the data slot is blocked.
REQ-034 Scenario: num_cols=0 -> only terminators 0/0, iact_write_en 1 pulse, FSM never enters ENCODE.
REQ-035 Scenario: rows=16, cols=8, all nonzero (128 > 126) -> err=1, final addr 126, terminators still emitted.
REQ-036 Scenario: reset=0 asserted while in ENCODE with both valids high -> valids 0 immediately (asynchronous); a following start encodes cleanly.
REQ-037 Scenario: start pulsed in WAIT_DONE, and iact_write_done pulsed in IDLE -> both ignored, no extra iact_write_en or done.
